// File: rtl/fft_pingpong_buf.sv
// fft_pingpong_buf: two-bank complex sample buffer between the receiver front
// end and the FFT. One bank fills while the other drains, in natural or
// bit-reversed order. Valid/ready handshakes on both sides, plus frame
// tracking, a sticky overflow flag and a synchronous flush.
// rst_n is asynchronous and active-high, despite its name.
module fft_pingpong_buf #(
  parameter int N     = 64,
  parameter int LOG2N = 6,
  parameter int Q     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Q-1:0]     in_r,
  input  logic [Q-1:0]     in_i,
  input  logic             bitrev_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q-1:0]     out_r,
  output logic [Q-1:0]     out_i,
  output logic [LOG2N-1:0] out_idx,
  output logic             out_last,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam logic [LOG2N-1:0] LAST_ADDR = LOG2N'(N - 1);

  // Both banks share one array; the bank number is the top address bit.
  logic [2*Q-1:0] mem [0:2*N-1];

  logic             wr_bank_reg;
  logic [LOG2N-1:0] wr_addr_reg;
  logic             rd_bank_reg;
  logic [LOG2N-1:0] rd_addr_reg;
  logic [1:0]       full_reg;
  logic [1:0]       full_next;
  logic             frame_mode_reg;

  logic             out_valid_reg;
  logic [Q-1:0]     out_r_reg;
  logic [Q-1:0]     out_i_reg;
  logic [LOG2N-1:0] out_idx_reg;
  logic             out_last_reg;
  logic             overflow_reg;

  logic             wr_fire;
  logic             rd_issue;
  logic             mode_eff;
  logic [LOG2N-1:0] rd_addr_rev;
  logic [LOG2N:0]   rd_mem_addr;

  assign in_ready  = !full_reg[wr_bank_reg];
  assign out_valid = out_valid_reg;
  assign out_r     = out_r_reg;
  assign out_i     = out_i_reg;
  assign out_idx   = out_idx_reg;
  assign out_last  = out_last_reg;
  assign overflow  = overflow_reg;

  // Flush suppresses any write or read in the same cycle.
  assign wr_fire  = in_valid && in_ready && !flush;
  assign rd_issue = full_reg[rd_bank_reg] && (!out_valid_reg || out_ready) && !flush;

  // The first issue of a frame uses bitrev_mode directly and latches it;
  // the remainder of the frame uses the latched copy.
  assign mode_eff = (rd_addr_reg == '0) ? bitrev_mode : frame_mode_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LOG2N; gi++) begin : g_rev
      assign rd_addr_rev[gi] = rd_addr_reg[LOG2N-1-gi];
    end
  endgenerate

  assign rd_mem_addr = {rd_bank_reg, (mode_eff ? rd_addr_rev : rd_addr_reg)};

  // Next full flags: the writer sets one bank while the reader clears the other.
  always_comb begin
    full_next = full_reg;
    if (wr_fire && (wr_addr_reg == LAST_ADDR)) full_next[wr_bank_reg] = 1'b1;
    if (rd_issue && (rd_addr_reg == LAST_ADDR)) full_next[rd_bank_reg] = 1'b0;
  end

  // Sample storage write port; contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank_reg, wr_addr_reg}] <= {in_r, in_i};
  end

  // Write pointer: advance per accepted sample, swap bank at end of frame.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_bank_reg <= 1'b0;
      wr_addr_reg <= '0;
    end else if (flush) begin
      wr_bank_reg <= 1'b0;
      wr_addr_reg <= '0;
    end else if (wr_fire) begin
      wr_addr_reg <= wr_addr_reg + 1'b1;
      if (wr_addr_reg == LAST_ADDR) wr_bank_reg <= !wr_bank_reg;
    end
  end

  // Read pointer, frame order latch and bank-full flags.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_bank_reg    <= 1'b0;
      rd_addr_reg    <= '0;
      frame_mode_reg <= 1'b0;
      full_reg       <= 2'b00;
    end else if (flush) begin
      rd_bank_reg    <= 1'b0;
      rd_addr_reg    <= '0;
      frame_mode_reg <= 1'b0;
      full_reg       <= 2'b00;
    end else begin
      full_reg <= full_next;
      if (rd_issue) begin
        rd_addr_reg <= rd_addr_reg + 1'b1;
        if (rd_addr_reg == '0) frame_mode_reg <= bitrev_mode;
        if (rd_addr_reg == LAST_ADDR) rd_bank_reg <= !rd_bank_reg;
      end
    end
  end

  // Output register doubles as the memory read register; holds under backpressure.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      out_valid_reg <= 1'b0;
      out_r_reg     <= '0;
      out_i_reg     <= '0;
      out_idx_reg   <= '0;
      out_last_reg  <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else if (rd_issue) begin
      out_valid_reg <= 1'b1;
      {out_r_reg, out_i_reg} <= mem[rd_mem_addr];
      out_idx_reg   <= rd_addr_reg;
      out_last_reg  <= (rd_addr_reg == LAST_ADDR);
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Sticky overflow on a dropped sample; a new drop wins over a clear.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      overflow_reg <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overflow_reg <= 1'b1;
    end else if (clr_overflow) begin
      overflow_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_pingpong_buf.sv
// Directed testbench for fft_pingpong_buf: one task per scenario, inline checks.
module tb_fft_pingpong_buf;

  localparam int N     = 64;
  localparam int LOG2N = 6;
  localparam int Q     = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [Q-1:0]     in_r = '0;
  logic [Q-1:0]     in_i = '0;
  logic             bitrev_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [Q-1:0]     out_r;
  logic [Q-1:0]     out_i;
  logic [LOG2N-1:0] out_idx;
  logic             out_last;
  logic             overflow;
  logic             clr_overflow = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  fft_pingpong_buf #(.N(N), .LOG2N(LOG2N), .Q(Q)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
    .bitrev_mode(bitrev_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
    .out_idx(out_idx), .out_last(out_last),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rev6(input int v);
    int r;
    r = 0;
    for (int b = 0; b < LOG2N; b++) if (v & (1 << b)) r |= 1 << (LOG2N - 1 - b);
    return r;
  endfunction

  // Offer `cnt` samples r=base+k, i=-(base+k), one per clock.
  task automatic write_seq(input int base, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      in_valid = 1'b1;
      in_r = Q'(base + k);
      in_i = Q'(-(base + k));
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) step();
    tests_run++;
    if (out_valid !== 1'b0 || out_r !== '0 || out_i !== '0 || out_idx !== '0 ||
        out_last !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b r=%h i=%h idx=%0d last=%b ovf=%b, required all 0",
               out_valid, out_r, out_i, out_idx, out_last, overflow);
    end
    rst_n = 1'b0;
    step();
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_natural();
    bitrev_mode = 1'b0;
    out_ready = 1'b1;
    write_seq(0, N);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL natural_latency_early: out_valid=%b right after 64th write, required 0", out_valid);
    end
    step();
    for (int j = 0; j < N; j++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_r !== Q'(j) || out_i !== Q'(-j) ||
          out_idx !== LOG2N'(j) || out_last !== (j == N - 1)) begin
        tests_failed++;
        $display("FAIL natural_beat%0d: valid=%b r=%0d i=%0d idx=%0d last=%b, required 1 %0d %0d %0d %b",
                 j, out_valid, $signed(out_r), $signed(out_i), out_idx, out_last, j, -j, j, j == N - 1);
      end
      $display("[TB] natural idx=%0d r=%0d i=%0d last=%b", out_idx, $signed(out_r), $signed(out_i), out_last);
      step();
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL natural_end: out_valid=%b after frame, required 0", out_valid);
    end
  endtask

  task automatic test_bitrev();
    bitrev_mode = 1'b1;
    out_ready = 1'b1;
    write_seq(0, N);
    step();
    for (int j = 0; j < N; j++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_r !== Q'(rev6(j)) || out_i !== Q'(-rev6(j)) ||
          out_idx !== LOG2N'(j) || out_last !== (j == N - 1)) begin
        tests_failed++;
        $display("FAIL bitrev_beat%0d: valid=%b r=%0d idx=%0d last=%b, required 1 %0d %0d %b",
                 j, out_valid, $signed(out_r), out_idx, out_last, rev6(j), j, j == N - 1);
      end
      $display("[TB] bitrev idx=%0d r=%0d", out_idx, $signed(out_r));
      if (j == 5) bitrev_mode = 1'b0;  // mid-frame change must be ignored
      step();
    end
    bitrev_mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n_out;
    n_out = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_r = '0;
    in_i = '0;
    for (int c = 1; c <= 260; c++) begin
      step();
      if (c < 3 * N) begin
        in_r = Q'(c);
        in_i = Q'(-c);
        tests_run++;
        if (in_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_in_ready_c%0d: got %b, required 1", c, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      tests_run++;
      if (out_valid !== (c >= N + 1 && c <= 4 * N)) begin
        tests_failed++;
        $display("FAIL b2b_valid_c%0d: got %b, required %b", c, out_valid, (c >= N + 1 && c <= 4 * N));
      end
      if (out_valid) begin
        tests_run++;
        if (out_r !== Q'(n_out) || out_idx !== LOG2N'(n_out % N) || out_last !== (n_out % N == N - 1)) begin
          tests_failed++;
          $display("FAIL b2b_beat%0d: r=%0d idx=%0d last=%b, required %0d %0d %b",
                   n_out, $signed(out_r), out_idx, out_last, n_out, n_out % N, n_out % N == N - 1);
        end
        $display("[TB] b2b beat=%0d r=%0d idx=%0d", n_out, $signed(out_r), out_idx);
        n_out++;
      end
    end
    tests_run++;
    if (n_out != 3 * N || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_totals: beats=%0d overflow=%b, required %0d 0", n_out, overflow, 3 * N);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    write_seq(0, 2 * N);
    tests_run++;
    if (in_ready !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_after128: in_ready=%b overflow=%b, required 0 0", in_ready, overflow);
    end
    in_valid = 1'b1;
    in_r = Q'(999);
    in_i = Q'(999);
    step();
    in_valid = 1'b0;
    $display("[TB] ovf offered sample 129 (r=999)");
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set: overflow=%b, required 1", overflow);
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_r !== '0 || out_idx !== '0) begin
      tests_failed++;
      $display("FAIL ovf_stalled_head: valid=%b r=%0d idx=%0d, required 1 0 0", out_valid, out_r, out_idx);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 2 * N; j++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_r !== Q'(j) || out_idx !== LOG2N'(j % N)) begin
        tests_failed++;
        $display("FAIL ovf_drain%0d: valid=%b r=%0d idx=%0d, required 1 %0d %0d",
                 j, out_valid, $signed(out_r), out_idx, j, j % N);
      end
      $display("[TB] ovf drain r=%0d idx=%0d", $signed(out_r), out_idx);
      step();
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_no_extra: out_valid=%b r=%0d, required 0", out_valid, $signed(out_r));
    end
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    tests_run++;
    if (overflow !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_clear: overflow=%b in_ready=%b, required 0 1", overflow, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int exp;
    logic prev_stall;
    logic [Q-1:0] prev_r;
    logic [LOG2N-1:0] prev_idx;
    logic p;
    exp = 0;
    prev_stall = 1'b0;
    prev_r = '0;
    prev_idx = '0;
    out_ready = 1'b0;
    write_seq(0, N);
    step();
    for (int t = 0; t < 400 && exp < N; t++) begin
      p = (t % 4 == 0) || (t % 4 == 3);
      out_ready = p;
      if (out_valid) begin
        if (prev_stall) begin
          tests_run++;
          if (out_r !== prev_r || out_idx !== prev_idx) begin
            tests_failed++;
            $display("FAIL bp_hold_t%0d: r=%0d idx=%0d, required held %0d %0d",
                     t, out_r, out_idx, prev_r, prev_idx);
          end
        end
        if (p) begin
          tests_run++;
          if (out_r !== Q'(exp) || out_idx !== LOG2N'(exp)) begin
            tests_failed++;
            $display("FAIL bp_beat%0d: r=%0d idx=%0d, required %0d %0d", exp, out_r, out_idx, exp, exp);
          end
          $display("[TB] bp accept idx=%0d r=%0d", out_idx, out_r);
          exp++;
        end
      end
      prev_stall = out_valid && !p;
      prev_r = out_r;
      prev_idx = out_idx;
      step();
    end
    tests_run++;
    if (exp != N || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_totals: accepted=%0d valid=%b, required %0d 0", exp, out_valid, N);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_flush();
    int waited;
    out_ready = 1'b0;
    write_seq(700, N);
    write_seq(500, 40);
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_pre_inflight: out_valid=%b, required 1", out_valid);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    $display("[TB] flush asserted");
    tests_run++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_state: valid=%b last=%b in_ready=%b, required 0 0 1", out_valid, out_last, in_ready);
    end
    out_ready = 1'b1;
    repeat (2) step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no_stale: out_valid=%b r=%0d, required 0", out_valid, out_r);
    end
    write_seq(200, N);
    waited = 0;
    while (out_valid !== 1'b1 && waited < 5) begin
      step();
      waited++;
    end
    tests_run++;
    if (waited != 1) begin
      tests_failed++;
      $display("FAIL flush_latency: waited %0d cycles, required 1", waited);
    end
    for (int j = 0; j < N; j++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_r !== Q'(200 + j) || out_idx !== LOG2N'(j)) begin
        tests_failed++;
        $display("FAIL flush_fresh%0d: valid=%b r=%0d idx=%0d, required 1 %0d %0d",
                 j, out_valid, out_r, out_idx, 200 + j, j);
      end
      $display("[TB] flush fresh idx=%0d r=%0d", out_idx, out_r);
      step();
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_end: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    write_seq(0, N);
    repeat (10) step();
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_pre: out_valid=%b mid-readout, required 1", out_valid);
    end
    #2;
    rst_n = 1'b1;
    #1;
    $display("[TB] async reset asserted mid-readout");
    tests_run++;
    if (out_valid !== 1'b0 || out_r !== '0 || out_i !== '0 || out_idx !== '0 || out_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_outputs: valid=%b r=%0d i=%0d idx=%0d last=%b, required all 0",
               out_valid, out_r, out_i, out_idx, out_last);
    end
    repeat (2) step();
    rst_n = 1'b0;
    repeat (4) step();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_after: valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_natural();
    test_bitrev();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
